// File: rtl/store_monitor.sv
// Pass/fail monitor for the core's data-memory store bus, with a store trace FIFO.
// Ports: clk, reset (async, active-low), store bus in; verdict flags, counters, trace read port out.
//
//   clk          in   1      core clock
//   reset        in   1      async active-low reset
//   mem_write    in   1      store strobe
//   data_adr     in   32     store address
//   write_data   in   32     store data
//   done         out  1      PASS, FAIL or TMO reached
//   pass         out  1      run ended in PASS
//   fail         out  1      run ended in FAIL
//   timeout      out  1      run ended in TMO
//   fail_adr     out  32     address of failing store
//   fail_data    out  32     data of failing store
//   cycle_cnt    out  CNT_W  RUN cycles elapsed
//   store_cnt    out  16     stores seen in RUN (saturating)
//   log_valid    out  1      trace not empty
//   log_rd       in   1      trace pop request
//   log_adr      out  32     oldest trace address (show-ahead)
//   log_data     out  32     oldest trace data
//   log_overflow out  1      sticky dropped-push flag
module store_monitor #(
  parameter logic [31:0] PASS_ADDR    = 32'd100,
  parameter logic [31:0] PASS_DATA    = 32'd25,
  parameter logic [31:0] SCRATCH_ADDR = 32'd96,
  parameter int          TIMEOUT      = 1000,
  parameter int          CNT_W        = 32,
  parameter int          LOG_DEPTH    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_write,
  input  logic [31:0]      data_adr,
  input  logic [31:0]      write_data,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [31:0]      fail_adr,
  output logic [31:0]      fail_data,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [15:0]      store_cnt,
  output logic             log_valid,
  input  logic             log_rd,
  output logic [31:0]      log_adr,
  output logic [31:0]      log_data,
  output logic             log_overflow
);

  localparam int AW = $clog2(LOG_DEPTH);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_PASS = 2'd1;
  localparam logic [1:0] S_FAIL = 2'd2;
  localparam logic [1:0] S_TMO  = 2'd3;

  localparam logic [CNT_W-1:0] CYC_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [AW:0]      PTR_ONE  = (AW+1)'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [15:0]      sc_q, sc_d;
  logic [31:0]      fa_q, fa_d;
  logic [31:0]      fd_q, fd_d;

  logic in_run;
  logic hit_pass;
  logic hit_scr;

  assign in_run = (state_q == S_RUN);

  // X/Z on the bus leaves both compares non-true, so the
  // store falls through to FAIL in simulation.
  assign hit_pass = (data_adr == PASS_ADDR) &&
                    (write_data == PASS_DATA);
  assign hit_scr  = (data_adr == SCRATCH_ADDR);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    sc_d    = sc_q;
    fa_d    = fa_q;
    fd_d    = fd_q;
    if (in_run) begin
      cyc_d = cyc_q + CYC_ONE;
      if (mem_write) begin
        if (sc_q != 16'hFFFF) begin
          sc_d = sc_q + 16'd1;
        end
        if (hit_pass) begin
          state_d = S_PASS;
        end else if (hit_scr) begin
          state_d = S_RUN;
        end else begin
          state_d = S_FAIL;
          fa_d    = data_adr;
          fd_d    = write_data;
        end
      end
      // A terminal store in this cycle wins over timeout.
      if ((state_d == S_RUN) && (cyc_q == TMO_LAST)) begin
        state_d = S_TMO;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
      cyc_q   <= '0;
      sc_q    <= '0;
      fa_q    <= '0;
      fd_q    <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      sc_q    <= sc_d;
      fa_q    <= fa_d;
      fd_q    <= fd_d;
    end
  end

  assign done      = !in_run;
  assign pass      = (state_q == S_PASS);
  assign fail      = (state_q == S_FAIL);
  assign timeout   = (state_q == S_TMO);
  assign fail_adr  = fa_q;
  assign fail_data = fd_q;
  assign cycle_cnt = cyc_q;
  assign store_cnt = sc_q;

  // Trace FIFO: pointers carry one extra MSB so that
  // full and empty are distinguishable.
  logic [AW:0] wp_q, wp_d;
  logic [AW:0] rp_q, rp_d;
  logic        ovf_q, ovf_d;
  logic [31:0] adr_mem  [LOG_DEPTH];
  logic [31:0] data_mem [LOG_DEPTH];

  logic empty;
  logic full;
  logic push_req;
  logic push;
  logic pop;

  assign empty    = (wp_q == rp_q);
  assign full     = (wp_q[AW] != rp_q[AW]) &&
                    (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign push_req = in_run && mem_write;
  assign pop      = log_rd && !empty;
  // A simultaneous pop frees the slot the push needs.
  assign push     = push_req && (!full || pop);

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    ovf_d = ovf_q;
    if (push) begin
      wp_d = wp_q + PTR_ONE;
    end
    if (pop) begin
      rp_d = rp_q + PTR_ONE;
    end
    if (push_req && full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      ovf_q <= ovf_d;
    end
  end

  // Storage needs no reset: reads are masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      adr_mem[wp_q[AW-1:0]]  <= data_adr;
      data_mem[wp_q[AW-1:0]] <= write_data;
    end
  end

  assign log_valid    = !empty;
  assign log_overflow = ovf_q;
  assign log_adr      = empty ? 32'd0 : adr_mem[rp_q[AW-1:0]];
  assign log_data     = empty ? 32'd0 : data_mem[rp_q[AW-1:0]];

endmodule

// File: tb/tb_store_monitor.sv
// Self-checking bench for store_monitor.
// Scoreboard queue holds expected trace entries.
module tb_store_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] data_adr = '0;
  logic [31:0] write_data = '0;
  logic        done, pass, fail, timeout;
  logic [31:0] fail_adr, fail_data;
  logic [31:0] cycle_cnt;
  logic [15:0] store_cnt;
  logic        log_valid;
  logic        log_rd = 1'b0;
  logic [31:0] log_adr, log_data;
  logic        log_overflow;

  store_monitor dut (
    .clk          (clk),
    .reset        (reset),
    .mem_write    (mem_write),
    .data_adr     (data_adr),
    .write_data   (write_data),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .timeout      (timeout),
    .fail_adr     (fail_adr),
    .fail_data    (fail_data),
    .cycle_cnt    (cycle_cnt),
    .store_cnt    (store_cnt),
    .log_valid    (log_valid),
    .log_rd       (log_rd),
    .log_adr      (log_adr),
    .log_data     (log_data),
    .log_overflow (log_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int          m_st;
  logic [15:0] m_sc;
  logic        m_ovf;
  logic [31:0] m_fa, m_fd;
  logic [63:0] q[$];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string t);
    chk({t, ".done"}, done, m_st != 0);
    chk({t, ".pass"}, pass, m_st == 1);
    chk({t, ".fail"}, fail, m_st == 2);
    chk({t, ".tmo"}, timeout, m_st == 3);
    chk({t, ".scnt"}, store_cnt, m_sc);
    chk({t, ".ovf"}, log_overflow, m_ovf);
    chk({t, ".fadr"}, fail_adr, m_fa);
    chk({t, ".fdat"}, fail_data, m_fd);
    chk({t, ".lvld"}, log_valid, q.size() != 0);
  endtask

  task automatic model_clear();
    q.delete();
    m_st  = 0;
    m_sc  = '0;
    m_ovf = 1'b0;
    m_fa  = '0;
    m_fd  = '0;
  endtask

  task automatic do_reset(input string t);
    @(negedge clk);
    reset     = 1'b0;
    mem_write = 1'b0;
    log_rd    = 1'b0;
    model_clear();
    #1;
    check_state({t, ".rst"});
    chk({t, ".rst.cyc"}, cycle_cnt, 0);
    chk({t, ".rst.ladr"}, log_adr, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_store(input logic [31:0] a,
                             input logic [31:0] d,
                             input bit popped);
    if (m_st == 0) begin
      m_sc++;
      if (q.size() < 8 || popped) begin
        q.push_back({a, d});
      end else begin
        m_ovf = 1'b1;
      end
      if (a == 32'd100 && d == 32'd25) begin
        m_st = 1;
      end else if (a != 32'd96) begin
        m_st = 2;
        m_fa = a;
        m_fd = d;
      end
    end
  endtask

  task automatic store(input logic [31:0] a,
                       input logic [31:0] d);
    mem_write  = 1'b1;
    data_adr   = a;
    write_data = d;
    @(negedge clk);
    mem_write  = 1'b0;
    data_adr   = '0;
    write_data = '0;
    model_store(a, d, 1'b0);
  endtask

  task automatic pop_one(input string t);
    logic [63:0] e;
    if (q.size() == 0) begin
      chk({t, ".empty"}, log_valid, 0);
    end else begin
      e = q.pop_front();
      chk({t, ".lvld"}, log_valid, 1);
      chk({t, ".ladr"}, log_adr, e[63:32]);
      chk({t, ".ldat"}, log_data, e[31:0]);
      log_rd = 1'b1;
      @(negedge clk);
      log_rd = 1'b0;
    end
  endtask

  task automatic drain(input string t);
    while (q.size() != 0) pop_one(t);
    chk({t, ".drained"}, log_valid, 0);
    chk({t, ".zadr"}, log_adr, 0);
    chk({t, ".zdat"}, log_data, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // 1: scratch then pass
    do_reset("t1");
    idle(2);
    store(32'd96, 32'd7);
    idle(6);
    store(32'd100, 32'd25);
    check_state("t1");
    chk("t1.cyc", cycle_cnt, 10);
    idle(3);
    chk("t1.cycfrz", cycle_cnt, 10);
    drain("t1");

    // 2: fail, then later stores ignored
    do_reset("t2");
    idle(1);
    store(32'd104, 32'd25);
    check_state("t2");
    store(32'd100, 32'd25);
    check_state("t2b");
    drain("t2");

    // 3a: timeout
    do_reset("t3");
    idle(999);
    chk("t3.cyc999", cycle_cnt, 999);
    chk("t3.notmo", timeout, 0);
    idle(1);
    m_st = 3;
    check_state("t3");
    chk("t3.cyc", cycle_cnt, 1000);
    idle(4);
    chk("t3.cycfrz", cycle_cnt, 1000);

    // 3b: pass store on the timeout edge wins
    do_reset("t3b");
    idle(999);
    store(32'd100, 32'd25);
    check_state("t3b");
    chk("t3b.cyc", cycle_cnt, 1000);
    drain("t3b");

    // 4: overflow after ten scratch stores
    do_reset("t4");
    for (int i = 0; i < 10; i++) begin
      store(32'd96, 32'h100 + i);
    end
    check_state("t4");
    chk("t4.qsz", q.size(), 8);
    drain("t4");
    log_rd = 1'b1;
    @(negedge clk);
    log_rd = 1'b0;
    chk("t4.rdempty", log_valid, 0);
    check_state("t4b");

    // 5: async reset mid-run
    do_reset("t5");
    store(32'd96, 32'd1);
    store(32'd96, 32'd2);
    store(32'd96, 32'd3);
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    check_state("t5.async");
    chk("t5.cyc", cycle_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    store(32'd100, 32'd25);
    check_state("t5.rerun");
    drain("t5");

    // 6: full FIFO, simultaneous push and pop
    do_reset("t6");
    for (int i = 0; i < 8; i++) begin
      store(32'd96, 32'h200 + i);
    end
    chk("t6.full.ovf", log_overflow, 0);
    mem_write  = 1'b1;
    data_adr   = 32'd96;
    write_data = 32'hAA;
    log_rd     = 1'b1;
    begin
      logic [63:0] e;
      e = q.pop_front();
      chk("t6.head.adr", log_adr, e[63:32]);
      chk("t6.head.dat", log_data, e[31:0]);
    end
    @(negedge clk);
    mem_write  = 1'b0;
    log_rd     = 1'b0;
    data_adr   = '0;
    write_data = '0;
    model_store(32'd96, 32'hAA, 1'b1);
    check_state("t6");
    chk("t6.qsz", q.size(), 8);
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
